// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for clock_divider_prog; High exists only when DIVIDER_DUTY_PROG_EN is defined.
interface clock_divider_prog_if #(
  parameter int WIDTH = 8
);
  logic             Enable;
  logic             Sel;
  logic [WIDTH-1:0] Div;
`ifdef DIVIDER_DUTY_PROG_EN
  logic [WIDTH-1:0] High;
`endif
  logic             ClockOut;
  logic             Tick;
  logic             Pending;

`ifdef DIVIDER_DUTY_PROG_EN
  modport master (output Enable, Sel, Div, High, input ClockOut, Tick, Pending);
  modport slave  (input Enable, Sel, Div, High, output ClockOut, Tick, Pending);
`else
  modport master (output Enable, Sel, Div, input ClockOut, Tick, Pending);
  modport slave  (input Enable, Sel, Div, output ClockOut, Tick, Pending);
`endif
endinterface

// File: rtl/clock_divider_prog.sv
// Programmable glitch-free clock divider: ClockOut/Tick registered, changes applied only at period boundaries.
// Latency: ClockOut rises one edge after Enable is sampled; DIVIDER_DUTY_PROG_EN adds a programmable high time.
module clock_divider_prog #(
  parameter int WIDTH = 8,
  parameter int DIV_A = 4
) (
  input logic              Clock,
  input logic              nReset,
  clock_divider_prog_if.slave bus
);
  localparam int               PRE_I   = (DIV_A < 2) ? 2 : DIV_A;
  localparam logic [WIDTH-1:0] PRESET  = PRE_I[WIDTH-1:0];
  localparam int               PRE_HI  = (PRE_I + 1) / 2;
  localparam logic [WIDTH-1:0] PRESET_H = PRE_HI[WIDTH-1:0];

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt, activen, activeh;
  logic             clk_q, tick_q, pend_q;

  logic [WIDTH-1:0] raw, reqn, hreq, cnt_inc;
  logic             at_end, do_load, go_idle;

  always_comb begin
    raw  = bus.Sel ? bus.Div : PRESET;
    reqn = (raw < WIDTH'(2)) ? WIDTH'(2) : raw;
`ifdef DIVIDER_DUTY_PROG_EN
    // High time must leave at least one low cycle in the period
    if (bus.High < WIDTH'(1))
      hreq = WIDTH'(1);
    else if (bus.High > reqn - WIDTH'(1))
      hreq = reqn - WIDTH'(1);
    else
      hreq = bus.High;
`else
    hreq = (reqn >> 1) + {{(WIDTH-1){1'b0}}, reqn[0]};
`endif
  end

  assign cnt_inc = cnt + WIDTH'(1);
  assign at_end  = (state == ST_RUN) && (cnt == activen - WIDTH'(1));
  assign do_load = bus.Enable && ((state == ST_IDLE) || at_end);
  assign go_idle = !bus.Enable && ((state == ST_IDLE) || at_end);

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      activen <= PRESET;
      activeh <= PRESET_H;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else if (do_load) begin
      state   <= ST_RUN;
      cnt     <= '0;
      activen <= reqn;
      activeh <= hreq;
      clk_q   <= 1'b1;
      tick_q  <= 1'b1;
      pend_q  <= 1'b0;
    end else if (go_idle) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      // mid-period: the running period is frozen, only Pending tracks the request
      cnt    <= cnt_inc;
      clk_q  <= (cnt_inc < activeh);
      tick_q <= 1'b0;
      pend_q <= (reqn != activen) || (hreq != activeh);
    end
  end

  assign bus.ClockOut = clk_q;
  assign bus.Tick     = tick_q;
  assign bus.Pending  = pend_q;
endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog (DIV_A=4); covers DIVIDER_DUTY_PROG_EN cases when defined.
module tb_clock_divider_prog;
  logic clk;
  logic nrst;
  int   checks = 0;
  int   errors = 0;

  clock_divider_prog_if #(.WIDTH(8)) bus ();
  clock_divider_prog #(.WIDTH(8), .DIV_A(4)) dut (
    .Clock (clk),
    .nReset(nrst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       sel;
    logic [7:0] div;
    logic [7:0] high;
    logic       c;
    logic       t;
    logic       p;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic sel, input logic [7:0] div, input logic [7:0] high,
                     input logic c, input logic t, input logic p, input string nm);
    vec_t v;
    v.en = en; v.sel = sel; v.div = div; v.high = high;
    v.c = c; v.t = t; v.p = p; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic sel, input logic [7:0] div, input logic [7:0] high);
    bus.Enable = en;
    bus.Sel    = sel;
    bus.Div    = div;
`ifdef DIVIDER_DUTY_PROG_EN
    bus.High   = high;
`else
    if (high == 8'hFF) bus.Div = div;
`endif
  endtask

  // inputs are applied 1 time unit after an edge, outputs sampled 1 unit after the next edge
  task automatic step(input logic en, input logic sel, input logic [7:0] div, input logic [7:0] high,
                      input logic c, input logic t, input logic p, input string nm);
    drive(en, sel, div, high);
    @(posedge clk);
    #1;
    chk({nm, ".clk"}, bus.ClockOut, c);
    chk({nm, ".tick"}, bus.Tick, t);
    chk({nm, ".pend"}, bus.Pending, p);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd2);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.clk", bus.ClockOut, 1'b0);
    chk("rst.tick", bus.Tick, 1'b0);
    chk("rst.pend", bus.Pending, 1'b0);
    nrst = 1'b1;
  endtask

  initial begin
    // T1: preset N=4 -> 1100
    add(1,0,0,2, 1,1,0,"t1.e1"); add(1,0,0,2, 1,0,0,"t1.e2");
    add(1,0,0,2, 0,0,0,"t1.e3"); add(1,0,0,2, 0,0,0,"t1.e4");
    add(1,0,0,2, 1,1,0,"t1.e5"); add(1,0,0,2, 1,0,0,"t1.e6");
    add(1,0,0,2, 0,0,0,"t1.e7"); add(1,0,0,2, 0,0,0,"t1.e8");
    // T2: switch to Div=7 while cnt=1; current period finishes, then 1111000
    add(1,0,0,2, 1,1,0,"t2.e9");  add(1,0,0,2, 1,0,0,"t2.e10");
    add(1,1,7,4, 0,0,1,"t2.e11"); add(1,1,7,4, 0,0,1,"t2.e12");
    add(1,1,7,4, 1,1,0,"t2.e13"); add(1,1,7,4, 1,0,0,"t2.e14");
    add(1,1,7,4, 1,0,0,"t2.e15"); add(1,1,7,4, 1,0,0,"t2.e16");
    add(1,1,7,4, 0,0,0,"t2.e17"); add(1,1,7,4, 0,0,0,"t2.e18");
    add(1,1,7,4, 0,0,0,"t2.e19"); add(1,1,7,4, 1,1,0,"t2.e20");
    // T3: Div=0 then Div=1 both clamp to 2
    add(1,1,0,1, 1,0,1,"t3.e21"); add(1,1,0,1, 1,0,1,"t3.e22");
    add(1,1,0,1, 1,0,1,"t3.e23"); add(1,1,0,1, 0,0,1,"t3.e24");
    add(1,1,0,1, 0,0,1,"t3.e25"); add(1,1,0,1, 0,0,1,"t3.e26");
    add(1,1,0,1, 1,1,0,"t3.e27"); add(1,1,0,1, 0,0,0,"t3.e28");
    add(1,1,1,1, 1,1,0,"t3.e29"); add(1,1,1,1, 0,0,0,"t3.e30");
    add(1,1,1,1, 1,1,0,"t3.e31"); add(1,1,1,1, 0,0,0,"t3.e32");
    // T4: N=6, Enable dropped at cnt=2 -> period completes, then idle; re-enable
    add(1,1,6,3, 1,1,0,"t4.e33"); add(1,1,6,3, 1,0,0,"t4.e34");
    add(1,1,6,3, 1,0,0,"t4.e35"); add(0,1,6,3, 0,0,0,"t4.e36");
    add(0,1,6,3, 0,0,0,"t4.e37"); add(0,1,6,3, 0,0,0,"t4.e38");
    add(0,1,6,3, 0,0,0,"t4.e39"); add(0,1,6,3, 0,0,0,"t4.e40");
    add(1,1,6,3, 1,1,0,"t4.e41"); add(1,1,6,3, 1,0,0,"t4.e42");
    add(1,1,6,3, 1,0,0,"t4.e43"); add(1,1,6,3, 0,0,0,"t4.e44");

    nrst = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd2);
    #1;
    do_reset();
    foreach (vecs[i])
      step(vecs[i].en, vecs[i].sel, vecs[i].div, vecs[i].high, vecs[i].c, vecs[i].t, vecs[i].p, vecs[i].nm);

    // T5: reset at cnt=3 of N=7 with a pending request, restart on the preset
    do_reset();
    step(1,1,7,4, 1,1,0,"t5.s0");
    step(1,1,7,4, 1,0,0,"t5.s1");
    step(1,1,7,4, 1,0,0,"t5.s2");
    step(1,1,5,4, 1,0,1,"t5.s3");
    nrst = 1'b0;
    step(1,1,5,4, 0,0,0,"t5.rst");
    nrst = 1'b1;
    step(1,0,0,2, 1,1,0,"t5.r1");
    step(1,0,0,2, 1,0,0,"t5.r2");
    step(1,0,0,2, 0,0,0,"t5.r3");
    step(1,0,0,2, 0,0,0,"t5.r4");
    step(1,0,0,2, 1,1,0,"t5.r5");

`ifdef DIVIDER_DUTY_PROG_EN
    // T6: High=1 -> 10000000, High=9 clamps to 7 -> 11111110
    do_reset();
    for (int k = 0; k < 8; k++)
      step(1,1,8,1, (k == 0), (k == 0), 0, $sformatf("t6.a%0d", k));
    for (int k = 0; k < 8; k++)
      step(1,1,8,9, (k < 7), (k == 0), 0, $sformatf("t6.b%0d", k));
    step(1,1,8,9, 1,1,0,"t6.wrap");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
